// File: rtl/ifetch_queue_pkg.sv
// Shared types and default sizing for the decoupled instruction fetch queue.
package ifetch_queue_pkg;

    localparam int IFQ_XLEN    = 32;
    localparam int IFQ_ILEN    = 32;
    localparam int IFQ_DEPTH   = 4;
    localparam int IFQ_MAX_OUT = 2;

    typedef struct packed {
        logic [IFQ_XLEN-1:0] pc;
        logic [31:0]         instr;
    } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// Registered-storage FIFO with synchronous flush; the head is read straight
// from storage, so a pushed entry becomes visible one cycle after the push.
module ifetch_queue_sync_fifo
    import ifetch_queue_pkg::*;
#(
    parameter type T     = ifq_entry_t,
    parameter int  DEPTH = IFQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_push,
    input  T                           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output T                           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wrPtr;
    logic [AW-1:0]  r_rdPtr;
    logic [CW-1:0]  r_count;
    logic           w_popEff;
    logic           w_pushEff;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rdPtr];

    // A full queue may still accept a push when the head leaves in the same cycle.
    assign w_popEff  = i_pop && !o_empty;
    assign w_pushEff = i_push && (!o_full || w_popEff);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushEff) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_popEff)  r_rdPtr <= r_rdPtr + AW'(1);
            r_count <= r_count + CW'(w_pushEff) - CW'(w_popEff);
        end
    end

    always_ff @(posedge clk) begin
        if (w_pushEff && !i_flush) r_mem[r_wrPtr] <= i_data;
    end

    a_countBound: assert property (@(posedge clk) disable iff (!reset_n)
        r_count <= CW'(DEPTH));
    a_noPushFull: assert property (@(posedge clk) disable iff (!reset_n)
        !(i_push && !i_flush && o_full && !w_popEff));

endmodule

// File: rtl/ifetch_queue.sv
// Fetch front-end: issues pipelined icache requests under a credit limit,
// queues responses for decode and discards in-flight responses after a redirect.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int XLEN    = IFQ_XLEN,
    parameter int ILEN    = IFQ_ILEN,
    parameter int DEPTH   = IFQ_DEPTH,
    parameter int MAX_OUT = IFQ_MAX_OUT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] reset_adr_i,
    output logic            icache_req_o,
    output logic [XLEN-1:0] icache_adr_o,
    input  logic            icache_gnt_i,
    input  logic            icache_rsp_v_i,
    input  logic [ILEN-1:0] icache_instr_i,
    input  logic            branch_v_q_i,
    input  logic [XLEN-1:0] pc_data_q_i,
    output logic            instr_v_o,
    output logic [ILEN-1:0] instr_q_o,
    output logic [XLEN-1:0] pc_q_o,
    input  logic            dec_ready_i
);

    localparam int            CW        = $clog2(DEPTH+1);
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
    localparam logic [CW:0]   DEPTH_C   = (CW+1)'(DEPTH);

    logic [XLEN-1:0] r_fetchPc;
    logic [XLEN-1:0] r_rspPc;
    logic [CW-1:0]   r_outst;
    logic [CW-1:0]   r_dropCnt;

    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_outstNext;
    logic            w_full;
    logic            w_empty;
    logic            w_req;
    logic            w_issue;
    logic            w_rspOk;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_target;
    ifq_entry_t      w_pushData;
    ifq_entry_t      w_head;

    // Credit rule: queued entries plus requests in flight never exceed DEPTH,
    // so every response is guaranteed a free slot when it returns.
    assign w_req    = reset_n && !branch_v_q_i && (r_outst < MAX_OUT_C)
                   && (({1'b0, w_count} + {1'b0, r_outst}) < DEPTH_C);
    assign w_issue  = w_req && icache_gnt_i;
    assign w_rspOk  = icache_rsp_v_i && (r_outst != '0);
    assign w_push   = w_rspOk && (r_dropCnt == '0) && !branch_v_q_i;
    assign w_pop    = !w_empty && dec_ready_i && !branch_v_q_i;
    assign w_target = pc_data_q_i & ~XLEN'(3);

    assign w_outstNext = r_outst + CW'(w_issue) - CW'(w_rspOk);

    assign w_pushData.pc    = r_rspPc;
    assign w_pushData.instr = icache_instr_i;

    // On a redirect every request still in flight becomes a response to discard.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetchPc <= reset_adr_i;
            r_rspPc   <= reset_adr_i;
            r_outst   <= '0;
            r_dropCnt <= '0;
        end else begin
            r_outst <= w_outstNext;
            if (branch_v_q_i) begin
                r_fetchPc <= w_target;
                r_rspPc   <= w_target;
                r_dropCnt <= w_outstNext;
            end else begin
                if (w_issue)                      r_fetchPc <= r_fetchPc + XLEN'(4);
                if (w_rspOk && r_dropCnt != '0)   r_dropCnt <= r_dropCnt - CW'(1);
                if (w_push)                       r_rspPc   <= r_rspPc + XLEN'(4);
            end
        end
    end

    ifetch_queue_sync_fifo #(
        .T     (ifq_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (w_pushData),
        .i_pop   (w_pop),
        .i_flush (branch_v_q_i),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign icache_req_o = w_req;
    assign icache_adr_o = r_fetchPc;
    assign instr_v_o    = !w_empty;
    assign instr_q_o    = w_empty ? '0 : w_head.instr;
    assign pc_q_o       = w_empty ? '0 : w_head.pc;

    a_noStrayRsp: assert property (@(posedge clk) disable iff (!reset_n)
        !(icache_rsp_v_i && r_outst == '0));
    a_outstBound: assert property (@(posedge clk) disable iff (!reset_n)
        r_outst <= MAX_OUT_C);
    a_dropBound:  assert property (@(posedge clk) disable iff (!reset_n)
        r_dropCnt <= r_outst);
    a_pushRoom:   assert property (@(posedge clk) disable iff (!reset_n)
        !(w_push && w_full && !w_pop));

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised bench for ifetch_queue: an icache model answers granted requests
// and a scoreboard of expected pc/instr pairs is checked by a separate monitor.
module tb_ifetch_queue;

    localparam int          DEPTH   = 4;
    localparam int          MAX_OUT = 2;
    localparam logic [31:0] BOOT    = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] reset_adr_i;
    logic        icache_req_o;
    logic [31:0] icache_adr_o;
    logic        icache_gnt_i;
    logic        icache_rsp_v_i;
    logic [31:0] icache_instr_i;
    logic        branch_v_q_i;
    logic [31:0] pc_data_q_i;
    logic        instr_v_o;
    logic [31:0] instr_q_o;
    logic [31:0] pc_q_o;
    logic        dec_ready_i;

    ifetch_queue #(
        .XLEN    (32),
        .ILEN    (32),
        .DEPTH   (DEPTH),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .reset_adr_i    (reset_adr_i),
        .icache_req_o   (icache_req_o),
        .icache_adr_o   (icache_adr_o),
        .icache_gnt_i   (icache_gnt_i),
        .icache_rsp_v_i (icache_rsp_v_i),
        .icache_instr_i (icache_instr_i),
        .branch_v_q_i   (branch_v_q_i),
        .pc_data_q_i    (pc_data_q_i),
        .instr_v_o      (instr_v_o),
        .instr_q_o      (instr_q_o),
        .pc_q_o         (pc_q_o),
        .dec_ready_i    (dec_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    pend_t       pendQ[$];
    exp_t        expQ[$];
    int          cycle       = 0;
    int          vectors     = 0;
    int          miscompares = 0;
    int          arrived     = 0;
    int          lastDue     = 0;
    logic [31:0] expNext;
    bit          rspStale    = 1'b0;
    int          gntPct, readyPct, branchPm, latMin, latMax;
    bit          forceBranch = 1'b0;
    logic [31:0] forceTarget = '0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic setMode(input int g, input int r, input int lmin, input int lmax, input int bpm);
        gntPct   = g;
        readyPct = r;
        latMin   = lmin;
        latMax   = lmax;
        branchPm = bpm;
    endtask

    // The icache model answers strictly in order, one response per cycle at most.
    task automatic applyStimulus();
        dec_ready_i  = ($urandom_range(99) < readyPct);
        icache_gnt_i = ($urandom_range(99) < gntPct);
        branch_v_q_i = forceBranch || ($urandom_range(999) < branchPm);
        pc_data_q_i  = forceBranch ? forceTarget : $urandom();
        forceBranch  = 1'b0;
        if (pendQ.size() > 0 && pendQ[0].due <= cycle) begin
            icache_rsp_v_i = 1'b1;
            icache_instr_i = memWord(pendQ[0].addr);
            rspStale       = pendQ[0].stale;
            pendQ.delete(0);
        end else begin
            icache_rsp_v_i = 1'b0;
            icache_instr_i = $urandom();
            rspStale       = 1'b0;
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            applyStimulus();
        end
    endtask

    task automatic idleInputs();
        icache_gnt_i   = 1'b0;
        icache_rsp_v_i = 1'b0;
        icache_instr_i = '0;
        branch_v_q_i   = 1'b0;
        pc_data_q_i    = '0;
        dec_ready_i    = 1'b0;
    endtask

    task automatic resetModel();
        pendQ.delete();
        expQ.delete();
        arrived  = 0;
        lastDue  = 0;
        rspStale = 1'b0;
        expNext  = reset_adr_i;
    endtask

    // Occupancy is derived from the scoreboard: live expected entries plus
    // requests in flight that a redirect has already condemned.
    task automatic monitorCycle();
        int    outst;
        int    staleOut;
        bit    reqExp;
        pend_t p;
        exp_t  e;
        outst    = pendQ.size() + (icache_rsp_v_i ? 1 : 0);
        staleOut = (icache_rsp_v_i && rspStale) ? 1 : 0;
        foreach (pendQ[i]) if (pendQ[i].stale) staleOut++;
        reqExp = !branch_v_q_i && (outst < MAX_OUT) && ((expQ.size() + staleOut) < DEPTH);
        checkOutput("icacheReq", 32'(icache_req_o), 32'(reqExp));
        checkOutput("instrValid", 32'(instr_v_o), 32'(arrived > 0));
        if (icache_req_o) checkOutput("icacheAdr", icache_adr_o, expNext);
        if (instr_v_o) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL headUnexpected: got pc 0x%08h, expected no entry (cycle %0d)", pc_q_o, cycle);
            end else begin
                checkOutput("headPc", pc_q_o, expQ[0].pc);
                checkOutput("headInstr", instr_q_o, expQ[0].instr);
            end
        end
        if (instr_v_o && dec_ready_i && !branch_v_q_i && expQ.size() > 0 && arrived > 0) begin
            expQ.delete(0);
            arrived--;
        end
        if (icache_rsp_v_i && !rspStale && !branch_v_q_i) arrived++;
        if (icache_req_o && icache_gnt_i) begin
            p.addr  = icache_adr_o;
            p.due   = cycle + int'($urandom_range(latMax, latMin));
            if (p.due <= lastDue) p.due = lastDue + 1;
            lastDue = p.due;
            p.stale = branch_v_q_i;
            pendQ.push_back(p);
            if (!branch_v_q_i) begin
                e.pc    = expNext;
                e.instr = memWord(expNext);
                expQ.push_back(e);
                expNext = expNext + 32'd4;
            end
        end
        if (branch_v_q_i) begin
            foreach (pendQ[i]) pendQ[i].stale = 1'b1;
            expQ.delete();
            arrived = 0;
            expNext = pc_data_q_i & ~32'h3;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset_n) monitorCycle();
        end
    end

    initial begin
        reset_n     = 1'b0;
        reset_adr_i = BOOT;
        idleInputs();
        setMode(100, 100, 1, 1, 0);
        resetModel();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("resetReq", 32'(icache_req_o), 32'd0);
        checkOutput("resetValid", 32'(instr_v_o), 32'd0);
        checkOutput("resetAdr", icache_adr_o, BOOT);
        checkOutput("resetPc", pc_q_o, 32'd0);
        checkOutput("resetInstr", instr_q_o, 32'd0);

        // Streaming with single-cycle icache latency.
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus();
        runCycles(20);

        // Decode stalls: the queue fills and issue stops on credit.
        setMode(100, 0, 1, 1, 0);
        runCycles(12);
        #2;
        checkOutput("fullReq", 32'(icache_req_o), 32'd0);
        checkOutput("fullValid", 32'(instr_v_o), 32'd1);
        setMode(100, 100, 1, 1, 0);
        runCycles(1);
        setMode(100, 0, 1, 1, 0);
        runCycles(6);

        // Longer latency limits outstanding requests.
        setMode(100, 80, 3, 3, 0);
        runCycles(40);

        // Redirect while two requests are in flight.
        setMode(100, 100, 3, 3, 0);
        for (int k = 0; k < 20 && pendQ.size() != 2; k++) runCycles(1);
        if (pendQ.size() != 2) begin
            miscompares++;
            $display("[TB] FAIL twoOutstanding: got %0d in flight, expected 2", pendQ.size());
        end
        vectors++;
        forceTarget = 32'h8000_0100;
        forceBranch = 1'b1;
        runCycles(15);

        // Redirect in the same cycle as a response and a grant.
        setMode(100, 100, 1, 1, 0);
        for (int k = 0; k < 20 && !(pendQ.size() > 0 && pendQ[0].due <= cycle + 1); k++) runCycles(1);
        forceTarget = 32'h8000_0200;
        forceBranch = 1'b1;
        runCycles(1);
        runCycles(1);
        #2;
        checkOutput("restartAdr", icache_adr_o, 32'h8000_0200);
        runCycles(8);

        // Address wrap at the top of the address space.
        forceTarget = 32'hFFFF_FFF8;
        forceBranch = 1'b1;
        runCycles(12);

        // Random traffic with occasional redirects.
        setMode(70, 70, 1, 4, 30);
        runCycles(600);

        // Asynchronous reset in the middle of a burst.
        setMode(100, 50, 1, 2, 0);
        runCycles(10);
        @(negedge clk);
        applyStimulus();
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("midResetReq", 32'(icache_req_o), 32'd0);
        checkOutput("midResetValid", 32'(instr_v_o), 32'd0);
        checkOutput("midResetAdr", icache_adr_o, BOOT);
        idleInputs();
        resetModel();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        applyStimulus();
        runCycles(30);

        @(negedge clk);
        idleInputs();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
